// File: rtl/ethtransmit.sv
// GMII transmit frame engine: preamble/SFD, buffer readout, zero padding,
// FCS insertion from the shared CRC unit, inter-frame gap and done handshake.
module ethtransmit #(
    parameter int unsigned MINLEN = 60,
    parameter int unsigned MAXLEN = 1514,
    parameter int unsigned IFG    = 12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        txena,
    input  logic        txrdy,
    input  logic [10:0] txcntb,
    output logic [8:0]  txbaddr,
    input  logic [31:0] txbdata,
    input  logic [31:0] crc,
    output logic [7:0]  dataout,
    output logic        txen,
    output logic        txer,
    output logic        crcen,
    output logic        crcre,
    output logic        txdone
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_TX_DATA, S_TX_PAD, S_TX_CRC, S_TX_IFG, S_FINISH
    } state_t;

    localparam logic [10:0] MIN_L = 11'(MINLEN);
    localparam logic [10:0] MAX_L = 11'(MAXLEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG - 1);

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  dataout_q, dataout_d;
    logic [8:0]  txbaddr_q, txbaddr_d;
    logic        txen_q, txen_d;
    logic        crcen_q, crcen_d;
    logic        crcre_q, crcre_d;
    logic        txdone_q, txdone_d;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        sub_d     = sub_q;
        dataout_d = dataout_q;
        txbaddr_d = txbaddr_q;
        txen_d    = txen_q;
        crcen_d   = 1'b0;
        crcre_d   = crcre_q;
        txdone_d  = txdone_q;

        case (state_q)
            S_IDLE: begin
                crcre_d   = 1'b1;
                txen_d    = 1'b0;
                dataout_d = '0;
                txbaddr_d = '0;
                txdone_d  = 1'b0;
                if (txrdy && txena) begin
                    if (txcntb != '0) begin
                        len_d     = (txcntb > MAX_L) ? MAX_L : txcntb;
                        cnt_d     = '0;
                        sub_d     = '0;
                        state_d   = S_PREAMBLE;
                        dataout_d = 8'h55;
                        txen_d    = 1'b1;
                    end else begin
                        state_d  = S_FINISH;
                        txdone_d = 1'b1;
                    end
                end
            end
            S_PREAMBLE: begin
                if (sub_q == 8'd6) begin
                    state_d   = S_SFD;
                    dataout_d = 8'hD5;
                    crcre_d   = 1'b0;
                end else begin
                    sub_d     = sub_q + 8'd1;
                    dataout_d = 8'h55;
                end
            end
            // Outputs are registered, so each edge chooses the byte for the
            // coming cycle: next data lane, a pad byte, or FCS byte 0.
            S_SFD, S_TX_DATA, S_TX_PAD: begin
                if (cnt_q < len_q) begin
                    state_d = S_TX_DATA;
                    crcen_d = 1'b1;
                    cnt_d   = cnt_q + 11'd1;
                    if (cnt_q[1:0] == 2'd0) begin
                        dataout_d = txbdata[7:0];
                        sh_d      = {8'h00, txbdata[31:8]};
                        if (({1'b0, cnt_q} + 12'd4) < {1'b0, len_q})
                            txbaddr_d = txbaddr_q + 9'd1;
                    end else begin
                        dataout_d = sh_q[7:0];
                        sh_d      = {8'h00, sh_q[31:8]};
                    end
                end else if (cnt_q < MIN_L) begin
                    state_d   = S_TX_PAD;
                    crcen_d   = 1'b1;
                    cnt_d     = cnt_q + 11'd1;
                    dataout_d = '0;
                end else begin
                    state_d   = S_TX_CRC;
                    dataout_d = crc[7:0];
                    sh_d      = {8'h00, crc[31:8]};
                    sub_d     = '0;
                end
            end
            S_TX_CRC: begin
                if (sub_q == 8'd3) begin
                    state_d   = S_TX_IFG;
                    txen_d    = 1'b0;
                    dataout_d = '0;
                    crcre_d   = 1'b1;
                    sub_d     = '0;
                end else begin
                    dataout_d = sh_q[7:0];
                    sh_d      = {8'h00, sh_q[31:8]};
                    sub_d     = sub_q + 8'd1;
                end
            end
            S_TX_IFG: begin
                if (sub_q == IFG_LAST) begin
                    state_d   = S_FINISH;
                    txdone_d  = txrdy;
                    txbaddr_d = '0;
                end else begin
                    sub_d = sub_q + 8'd1;
                end
            end
            S_FINISH: begin
                txdone_d = txrdy;
                if (!txrdy) begin
                    state_d   = S_IDLE;
                    crcre_d   = 1'b1;
                    txbaddr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
            sub_q     <= '0;
            dataout_q <= '0;
            txbaddr_q <= '0;
            txen_q    <= 1'b0;
            crcen_q   <= 1'b0;
            crcre_q   <= 1'b1;
            txdone_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            sub_q     <= sub_d;
            dataout_q <= dataout_d;
            txbaddr_q <= txbaddr_d;
            txen_q    <= txen_d;
            crcen_q   <= crcen_d;
            crcre_q   <= crcre_d;
            txdone_q  <= txdone_d;
        end
    end

    assign dataout = dataout_q;
    assign txbaddr = txbaddr_q;
    assign txen    = txen_q;
    assign txer    = 1'b0;
    assign crcen   = crcen_q;
    assign crcre   = crcre_q;
    assign txdone  = txdone_q;

endmodule
